// File: rtl/seq_signed_mult8.sv
// Sequential signed multiplier: magnitude shift-add, one partial product per cycle, sign fixup.
// Optional macro SEQ_MULT_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module seq_signed_mult8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StSign, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH-1:0] acc_step;
    logic               last_step;

    always_comb begin
        pp       = mag_a_q & {WIDTH{mag_b_q[0]}};
        upper    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};
        acc_step = {upper, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last_step = (cnt_q == CW'(WIDTH - 1)) || ((mag_b_q >> 1) == '0);
`else
        last_step = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mag_a_d = A[WIDTH-1] ? (~A + 1'b1) : A;
                    mag_b_d = B[WIDTH-1] ? (~B + 1'b1) : B;
                    neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                acc_d   = acc_step;
                if (last_step) begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
                    // Skipped steps would only add zero and shift, so apply the shifts at once.
                    acc_d = acc_step >> (CW'(WIDTH - 1) - cnt_q);
`endif
                    state_d = StSign;
                end
            end
            StSign: begin
                if (acc_q == '0) begin
                    p_d = '0;
                end else begin
                    p_d = neg_q ? (~acc_q + 1'b1) : acc_q;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q == StRun) || (state_q == StSign);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_seq_signed_mult8.sv
// Randomized self-checking bench for seq_signed_mult8 against a plain-arithmetic model.
// Honours SEQ_MULT_EARLY_EXIT_EN for the expected latency.
module tb_seq_signed_mult8;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] P;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;

    seq_signed_mult8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_p(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, prod;
        logic [31:0] w;
        pa   = int'($signed(a));
        pb   = int'($signed(b));
        prod = pa * pb;
        w    = prod;
        return w[15:0];
    endfunction

    // Edges from the accepting edge (inclusive) until done is visible.
    function automatic int model_lat(input logic [7:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        logic [7:0] m;
        int r;
        m = b[7] ? (8'd0 - b) : b;
        r = 1;
        for (int i = 0; i < 8; i++) if (m[i]) r = i + 1;
        return r + 2;
`else
        return WIDTH + 2;
`endif
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int poke_at,
                          input bit noise);
        int lat;
        int busy_cnt;
        logic [15:0] exp_p;
        exp_p = model_p(a, b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        while (!done && lat < 40) begin
            busy_cnt += int'(busy);
            if (lat == poke_at) begin
                start = 1'b1;
                A = 8'd1;
                B = 8'd1;
            end else begin
                start = noise && ($urandom_range(0, 3) == 0);
                A = 8'($urandom);
                B = 8'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), 32'(model_lat(b)));
        check("product", 32'(P), 32'(exp_p));
        check("busy_cycles", 32'(busy_cnt), 32'(model_lat(b) - 1));
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("p_held", 32'(P), 32'(exp_p));
    endtask

    initial begin
        int seen;
        int prev;
        int pulses;
        int spacing;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        check("rst_p", 32'(P), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        run_op(8'd3, 8'd5, 3, 1'b0);
        run_op(8'hF9, 8'd6, 0, 1'b0);
        run_op(8'h80, 8'h80, 0, 1'b0);
        run_op(8'h80, 8'd127, 0, 1'b0);
        run_op(8'hFB, 8'd0, 0, 1'b0);
        run_op(8'd100, 8'd1, 0, 1'b0);
        run_op(8'hFF, 8'h80, 0, 1'b0);

        // Reset mid-RUN: previous P (0x0080) must clear at once, no done afterwards.
        @(negedge clk);
        A = 8'd77;
        B = 8'h80;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_p", 32'(P), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(done);
        end
        check("no_done_after_rst", 32'(seen), 32'd0);
        check("p_after_rst", 32'(P), 32'd0);
        run_op(8'hF9, 8'd6, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 8'($urandom), 0, 1'b1);
        end

        // Back-to-back with start held high.
        @(negedge clk);
        A = 8'd2;
        B = 8'd3;
        start = 1'b1;
        prev = -1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_p", 32'(P), 32'h6);
                if (prev >= 0) begin
                    spacing = i - prev;
                    check("b2b_spacing", 32'(spacing), 32'(model_lat(8'd3) + 1));
                end
                prev = i;
                pulses++;
            end
        end
        start = 1'b0;
        check("b2b_pulses_ge3", 32'(pulses >= 3), 32'd1);
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
